// File: rtl/river_pkg.sv
// Shared types and constants for the river-crossing game controller.
package river_pkg;

    // Game controller states.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MOVE  = 3'd1,
        S_CHECK = 3'd2,
        S_WIN   = 3'd3,
        S_LOSE  = 3'd4
    } state_t;

    // Column patterns for the two banks.
    localparam logic [7:0] BANK_L = 8'hC0;
    localparam logic [7:0] BANK_R = 8'h03;

    // Passenger encodings on the sel output.
    localparam logic [1:0] SEL_NONE  = 2'd0;
    localparam logic [1:0] SEL_CAT   = 2'd1;
    localparam logic [1:0] SEL_DOG   = 2'd2;
    localparam logic [1:0] SEL_MOUSE = 2'd3;

    // Number of animation steps in one crossing.
    localparam int STEPS_PER_CROSSING = 3;

    // One animation step: two columns toward the far bank.
    function automatic logic [7:0] step_pos(input logic [7:0] pos, input logic to_right);
        return to_right ? (pos >> 2) : (pos << 2);
    endfunction

endpackage

// File: rtl/river_game_ctrl_tick_gen.sv
// Modulo-N counter producing a one-cycle tick on its last count.
// A synchronous clear holds the count at zero, so the first tick after
// the clear drops comes exactly N cycles later.
module tick_gen #(
    parameter int N = 4
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int          W    = (N > 1) ? $clog2(N) : 1;
    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: wrap on the last value, hold at zero while cleared.
    always_comb begin
        count_d = count_q + 1'b1;
        if (clr_i || (count_q == LAST)) begin
            count_d = '0;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick_o = !clr_i && (count_q == LAST);

endmodule

// File: rtl/river_game_ctrl.sv
// Cat/dog/mouse river-crossing game controller. Tracks bank positions,
// animates boat crossings, checks the eating rules and detects a win.
// Produces column patterns and the row-scan counter for the dot matrix.
module river_game_ctrl
    import river_pkg::*;
#(
    parameter int SCAN_DIV = 1000,
    parameter int STEP_DIV = 25000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_cat,
    input  logic       btn_dog,
    input  logic       btn_mouse,
    input  logic       btn_go,
    output logic [2:0] cnt,
    output logic [7:0] cat,
    output logic [7:0] dog,
    output logic [7:0] mouse,
    output logic [7:0] farmer,
    output logic [1:0] sel,
    output logic       busy,
    output logic       win,
    output logic       lose,
    output state_t     dbg_state
);

    state_t     state_q;
    logic [7:0] cat_q, dog_q, mouse_q, farmer_q;
    logic [1:0] sel_q, sel_d;
    logic       busy_q, win_q, lose_q;
    logic       dir_right_q;
    logic [1:0] step_cnt_q;
    logic [2:0] cnt_q;

    logic       scan_tick;
    logic       step_tick;
    logic       step_clr;
    logic       cat_here, dog_here, mouse_here;
    logic [1:0] pick;
    logic [7:0] unattended;
    logic       lose_c, win_c;

    // Row-scan divider never pauses; the step divider only runs in MOVE.
    assign step_clr = (state_q != S_MOVE);

    tick_gen #(.N(SCAN_DIV)) u_scan_tick (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .clr_i   (1'b0),
        .tick_o  (scan_tick)
    );

    tick_gen #(.N(STEP_DIV)) u_step_tick (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .clr_i   (step_clr),
        .tick_o  (step_tick)
    );

    // An animal is selectable only when it shares the farmer's bank.
    assign cat_here   = (cat_q   == farmer_q);
    assign dog_here   = (dog_q   == farmer_q);
    assign mouse_here = (mouse_q == farmer_q);

    // Passenger selection: highest-priority valid press toggles sel.
    always_comb begin
        pick  = SEL_NONE;
        sel_d = sel_q;
        if (btn_cat && cat_here) begin
            pick = SEL_CAT;
        end else if (btn_dog && dog_here) begin
            pick = SEL_DOG;
        end else if (btn_mouse && mouse_here) begin
            pick = SEL_MOUSE;
        end
        if (pick != SEL_NONE) begin
            sel_d = (sel_q == pick) ? SEL_NONE : pick;
        end
    end

    // Rule evaluation on the bank the farmer has just left.
    always_comb begin
        unattended = (farmer_q == BANK_R) ? BANK_L : BANK_R;
        lose_c = ((dog_q == unattended) && (cat_q == unattended)) ||
                 ((cat_q == unattended) && (mouse_q == unattended));
        win_c  = (cat_q == BANK_R) && (dog_q == BANK_R) &&
                 (mouse_q == BANK_R) && (farmer_q == BANK_R);
    end

    // Row-scan counter, advanced by the scan tick and wrapping 7 to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 3'd0;
        end else if (scan_tick) begin
            cnt_q <= cnt_q + 3'd1;
        end
    end

    // Game FSM with all game outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cat_q       <= BANK_L;
            dog_q       <= BANK_L;
            mouse_q     <= BANK_L;
            farmer_q    <= BANK_L;
            sel_q       <= SEL_NONE;
            busy_q      <= 1'b0;
            win_q       <= 1'b0;
            lose_q      <= 1'b0;
            dir_right_q <= 1'b1;
            step_cnt_q  <= 2'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (btn_go) begin
                        // Go takes precedence; any same-cycle selection is dropped.
                        state_q     <= S_MOVE;
                        busy_q      <= 1'b1;
                        dir_right_q <= (farmer_q == BANK_L);
                        step_cnt_q  <= 2'd0;
                    end else begin
                        sel_q <= sel_d;
                    end
                end

                S_MOVE: begin
                    if (step_tick) begin
                        farmer_q <= step_pos(farmer_q, dir_right_q);
                        case (sel_q)
                            SEL_CAT:   cat_q   <= step_pos(cat_q, dir_right_q);
                            SEL_DOG:   dog_q   <= step_pos(dog_q, dir_right_q);
                            SEL_MOUSE: mouse_q <= step_pos(mouse_q, dir_right_q);
                            default:   ;
                        endcase
                        if (step_cnt_q == 2'(STEPS_PER_CROSSING - 1)) begin
                            // Boat has landed; busy drops as MOVE is left.
                            state_q    <= S_CHECK;
                            busy_q     <= 1'b0;
                            step_cnt_q <= 2'd0;
                        end else begin
                            step_cnt_q <= step_cnt_q + 2'd1;
                        end
                    end
                end

                S_CHECK: begin
                    sel_q  <= SEL_NONE;
                    busy_q <= 1'b0;
                    // Losing takes precedence over winning.
                    if (lose_c) begin
                        state_q <= S_LOSE;
                        lose_q  <= 1'b1;
                    end else if (win_c) begin
                        state_q <= S_WIN;
                        win_q   <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end

                S_WIN, S_LOSE: begin
                    if (btn_go) begin
                        state_q  <= S_IDLE;
                        cat_q    <= BANK_L;
                        dog_q    <= BANK_L;
                        mouse_q  <= BANK_L;
                        farmer_q <= BANK_L;
                        sel_q    <= SEL_NONE;
                        busy_q   <= 1'b0;
                        win_q    <= 1'b0;
                        lose_q   <= 1'b0;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign cnt       = cnt_q;
    assign cat       = cat_q;
    assign dog       = dog_q;
    assign mouse     = mouse_q;
    assign farmer    = farmer_q;
    assign sel       = sel_q;
    assign busy      = busy_q;
    assign win       = win_q;
    assign lose      = lose_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_river_game_ctrl.sv
// Self-checking bench for river_game_ctrl with short divider periods.
module tb_river_game_ctrl;
    import river_pkg::*;

    localparam int SCAN_DIV = 2;
    localparam int STEP_DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       btn_cat = 1'b0, btn_dog = 1'b0, btn_mouse = 1'b0, btn_go = 1'b0;
    logic [2:0] cnt;
    logic [7:0] cat, dog, mouse, farmer;
    logic [1:0] sel;
    logic       busy, win, lose;
    state_t     dbg_state;

    int checks = 0;
    int errors = 0;

    // Snapshot: {cat, dog, mouse, farmer, sel, busy, win, lose}
    logic [36:0] exp_q[$];

    // Bench-side record of where everything should be.
    logic [7:0] m_cat, m_dog, m_mouse, m_farmer;

    typedef struct {
        logic       c;
        logic       d;
        logic       m;
        logic [1:0] exp_sel;
        string      name;
    } sel_vec_t;

    sel_vec_t vecs[9];

    river_game_ctrl #(.SCAN_DIV(SCAN_DIV), .STEP_DIV(STEP_DIV)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_cat   (btn_cat),
        .btn_dog   (btn_dog),
        .btn_mouse (btn_mouse),
        .btn_go    (btn_go),
        .cnt       (cnt),
        .cat       (cat),
        .dog       (dog),
        .mouse     (mouse),
        .farmer    (farmer),
        .sel       (sel),
        .busy      (busy),
        .win       (win),
        .lose      (lose),
        .dbg_state (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    function automatic logic [36:0] pack(input logic [7:0] c, input logic [7:0] d,
                                         input logic [7:0] m, input logic [7:0] f,
                                         input logic [1:0] s, input logic b,
                                         input logic w, input logic l);
        return {c, d, m, f, s, b, w, l};
    endfunction

    function automatic logic [36:0] model_snap(input logic [1:0] s, input logic b,
                                               input logic w, input logic l);
        return pack(m_cat, m_dog, m_mouse, m_farmer, s, b, w, l);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sb_push(input logic [36:0] e);
        exp_q.push_back(e);
    endtask

    task automatic sb_check(input string name);
        logic [36:0] e;
        logic [36:0] a;
        checks++;
        a = pack(cat, dog, mouse, farmer, sel, busy, win, lose);
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: got %0h with no expected entry queued", name, a);
        end else begin
            e = exp_q.pop_front();
            if (a !== e) begin
                errors++;
                $display("FAIL %s: got cat/dog/mouse/farmer/sel/busy/win/lose=%0h expected %0h",
                         name, a, e);
            end
        end
    endtask

    task automatic model_reset();
        m_cat = BANK_L; m_dog = BANK_L; m_mouse = BANK_L; m_farmer = BANK_L;
    endtask

    // Drive one cycle of buttons, then sample 1 ns after the edge.
    task automatic pulse(input logic c, input logic d, input logic m, input logic g);
        @(negedge clk);
        btn_cat = c; btn_dog = d; btn_mouse = m; btn_go = g;
        @(posedge clk);
        #1;
        btn_cat = 1'b0; btn_dog = 1'b0; btn_mouse = 1'b0; btn_go = 1'b0;
    endtask

    task automatic sel_step(input logic c, input logic d, input logic m,
                            input logic [1:0] exp_sel, input string name);
        sb_push(model_snap(exp_sel, 1'b0, 1'b0, 1'b0));
        pulse(c, d, m, 1'b0);
        sb_check(name);
    endtask

    // Full crossing, checked every cycle from the go edge through CHECK.
    task automatic do_crossing(input logic [1:0] who, input logic extra_dog,
                               input logic exp_win, input logic exp_lose,
                               input string name);
        logic [7:0] fr[4];
        logic [7:0] pos;
        state_t     exp_state;
        if (m_farmer == BANK_L) fr = '{8'hC0, 8'h30, 8'h0C, 8'h03};
        else                    fr = '{8'h03, 8'h0C, 8'h30, 8'hC0};
        pulse(1'b0, extra_dog, 1'b0, 1'b1);
        for (int t = 0; t <= 12; t++) begin
            if (t > 0) begin
                @(posedge clk);
                #1;
            end
            pos = fr[t / 4];
            sb_push(pack((who == SEL_CAT)   ? pos : m_cat,
                         (who == SEL_DOG)   ? pos : m_dog,
                         (who == SEL_MOUSE) ? pos : m_mouse,
                         pos, who, (t < 12), 1'b0, 1'b0));
            sb_check({name, "_move"});
        end
        @(posedge clk);
        #1;
        m_farmer = fr[3];
        if (who == SEL_CAT)   m_cat   = fr[3];
        if (who == SEL_DOG)   m_dog   = fr[3];
        if (who == SEL_MOUSE) m_mouse = fr[3];
        sb_push(model_snap(SEL_NONE, 1'b0, exp_win, exp_lose));
        sb_check({name, "_check"});
        exp_state = exp_lose ? S_LOSE : (exp_win ? S_WIN : S_IDLE);
        check({name, "_state"}, 64'(dbg_state), 64'(exp_state));
    endtask

    task automatic restart(input string name);
        model_reset();
        sb_push(model_snap(SEL_NONE, 1'b0, 1'b0, 1'b0));
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        sb_check(name);
        check({name, "_state"}, 64'(dbg_state), 64'(S_IDLE));
    endtask

    // Watchdog
    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Main test
    initial begin
        vecs[0] = '{c: 1'b1, d: 1'b1, m: 1'b0, exp_sel: SEL_CAT,   name: "sel_cat_dog_prio"};
        vecs[1] = '{c: 1'b1, d: 1'b0, m: 1'b0, exp_sel: SEL_NONE,  name: "sel_cat_toggle"};
        vecs[2] = '{c: 1'b0, d: 1'b1, m: 1'b0, exp_sel: SEL_DOG,   name: "sel_dog"};
        vecs[3] = '{c: 1'b0, d: 1'b1, m: 1'b1, exp_sel: SEL_NONE,  name: "sel_dog_mouse_prio"};
        vecs[4] = '{c: 1'b0, d: 1'b0, m: 1'b1, exp_sel: SEL_MOUSE, name: "sel_mouse"};
        vecs[5] = '{c: 1'b1, d: 1'b1, m: 1'b1, exp_sel: SEL_CAT,   name: "sel_all_prio"};
        vecs[6] = '{c: 1'b0, d: 1'b0, m: 1'b1, exp_sel: SEL_MOUSE, name: "sel_switch_mouse"};
        vecs[7] = '{c: 1'b0, d: 1'b0, m: 1'b1, exp_sel: SEL_NONE,  name: "sel_mouse_toggle"};
        vecs[8] = '{c: 1'b0, d: 1'b0, m: 1'b0, exp_sel: SEL_NONE,  name: "sel_idle_hold"};

        // Reset
        model_reset();
        #2 rst_n = 1'b0;
        #20;
        sb_push(model_snap(SEL_NONE, 1'b0, 1'b0, 1'b0));
        sb_check("reset_outputs");
        check("reset_cnt", 64'(cnt), 64'(0));
        check("reset_state", 64'(dbg_state), 64'(S_IDLE));
        @(negedge clk);
        rst_n = 1'b1;

        // Scan counter advances every SCAN_DIV edges and wraps at 16
        for (int k = 1; k <= 17; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("scan_cnt_%0d", k), 64'(cnt), 64'((k / 2) % 8));
        end

        // Selection table, all animals on the farmer's bank
        for (int i = 0; i < 9; i++) begin
            sel_step(vecs[i].c, vecs[i].d, vecs[i].m, vecs[i].exp_sel, vecs[i].name);
        end

        // Mouse first leaves cat with dog: lose
        sel_step(1'b0, 1'b0, 1'b1, SEL_MOUSE, "sel_mouse_first");
        do_crossing(SEL_MOUSE, 1'b0, 1'b0, 1'b1, "mouse_first");
        sb_push(model_snap(SEL_NONE, 1'b0, 1'b0, 1'b1));
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        sb_check("lose_frozen");
        restart("restart_after_lose");

        // Go with dog in the same cycle: farmer crosses alone
        do_crossing(SEL_NONE, 1'b1, 1'b0, 1'b1, "go_with_dog");
        restart("restart_after_go_dog");

        // Winning sequence
        sel_step(1'b1, 1'b0, 1'b0, SEL_CAT, "win_sel_cat1");
        do_crossing(SEL_CAT, 1'b0, 1'b0, 1'b0, "win_cat_over");
        do_crossing(SEL_NONE, 1'b0, 1'b0, 1'b0, "win_back_empty1");
        sel_step(1'b1, 1'b0, 1'b0, SEL_NONE, "cat_far_ignored");
        sel_step(1'b0, 1'b1, 1'b0, SEL_DOG, "win_sel_dog");
        do_crossing(SEL_DOG, 1'b0, 1'b0, 1'b0, "win_dog_over");
        sel_step(1'b1, 1'b0, 1'b0, SEL_CAT, "win_sel_cat2");
        do_crossing(SEL_CAT, 1'b0, 1'b0, 1'b0, "win_cat_back");
        sel_step(1'b0, 1'b0, 1'b1, SEL_MOUSE, "win_sel_mouse");
        do_crossing(SEL_MOUSE, 1'b0, 1'b0, 1'b0, "win_mouse_over");
        do_crossing(SEL_NONE, 1'b0, 1'b0, 1'b0, "win_back_empty2");
        sel_step(1'b1, 1'b0, 1'b0, SEL_CAT, "win_sel_cat3");
        do_crossing(SEL_CAT, 1'b0, 1'b1, 1'b0, "win_cat_final");
        check("win_all_right", 64'({cat, dog, mouse, farmer}), 64'(32'h03030303));
        sb_push(model_snap(SEL_NONE, 1'b0, 1'b1, 1'b0));
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        sb_check("win_frozen");
        restart("restart_after_win");

        // Asynchronous reset in the middle of a crossing
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (9) @(posedge clk);
        #1;
        check("mid_move_farmer", 64'(farmer), 64'(8'h0C));
        check("mid_move_busy", 64'(busy), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        sb_push(model_snap(SEL_NONE, 1'b0, 1'b0, 1'b0));
        sb_check("async_reset_outputs");
        check("async_reset_cnt", 64'(cnt), 64'(0));
        check("async_reset_state", 64'(dbg_state), 64'(S_IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
